// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   state_t     : controller states (RUN / LU_STALL / FREEZE, 2 bits)
//   ctrl_t      : bundle of the six pipeline control outputs
//   REG_ZERO    : register-file index of $zero
//   WORD_ZERO   : 32-bit zero word
//   ctrl_*()    : output patterns for run, load-use stall and freeze
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'b0;
    localparam logic [31:0] WORD_ZERO = 32'b0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
    } ctrl_t;

    // Normal flow; a taken branch squashes the instruction fetched behind it.
    function automatic ctrl_t ctrl_run(input logic branch_taken);
        ctrl_t c;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.if_id_flush  = branch_taken;
        c.id_ex_write  = 1'b1;
        c.id_ex_bubble = 1'b0;
        c.ex_mem_write = 1'b1;
        return c;
    endfunction

    // Hold PC and IF/ID, push a bubble into ID/EX, let the load move on.
    function automatic ctrl_t ctrl_stall();
        ctrl_t c;
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.if_id_flush  = 1'b0;
        c.id_ex_write  = 1'b1;
        c.id_ex_bubble = 1'b1;
        c.ex_mem_write = 1'b1;
        return c;
    endfunction

    // Whole pipeline holds while data memory is busy.
    function automatic ctrl_t ctrl_freeze();
        return '0;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> sequencing controller signal bundle.
//   master : pipeline side, drives hazard/branch/memory status, receives enables
//   slave  : controller side, the reverse
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_taken;
    logic       dmem_busy;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_bubble;
    logic       ex_mem_write;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use hazard compare (purely combinational).
//   id_rs, id_rt, id_uses_rt : source operands of the instruction in ID
//   ex_mem_read, ex_rt       : load flag and destination held in ID/EX
//   hz                       : ID instruction needs the value the load has not produced yet
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hz
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt & (ex_rt == id_rt);
        // $zero is never a real dependency even if a load targets it.
        hz = ex_mem_read & (ex_rt != REG_ZERO) & (rs_match | rt_match);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
//   clk, rst      : clock, asynchronous active-high reset
//   pipe (slave)  : hazard/branch/memory status in, stage enables/bubble/flush out
//   stall_cycles  : saturating count of cycles with pc_write=0
//   flush_count   : saturating count of IF/ID flushes
// Outputs are Mealy so enables act in the cycle the condition is seen.
// Priority: dmem_busy > load-use stall > branch flush.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_stall_ctrl_if.slave pipe,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] REM_INIT = 2'(LOAD_LAT - 1);

    state_t     state, state_next;
    state_t     ret_state, ret_state_next;
    logic [1:0] rem, rem_next;
    logic       hz;
    ctrl_t      ctrl;

    hazard_detect u_hazard_detect (
        .id_rs       (pipe.id_rs),
        .id_rt       (pipe.id_rt),
        .id_uses_rt  (pipe.id_uses_rt),
        .ex_mem_read (pipe.ex_mem_read),
        .ex_rt       (pipe.ex_rt),
        .hz          (hz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            rem       <= '0;
        end else begin
            state     <= state_next;
            ret_state <= ret_state_next;
            rem       <= rem_next;
        end
    end

    // rem counts bubbles still owed after the current one; it is left
    // untouched across a freeze so the total bubble count is unaffected.
    always_comb begin
        state_next     = state;
        ret_state_next = ret_state;
        rem_next       = rem;
        unique case (state)
            ST_RUN: begin
                if (pipe.dmem_busy) begin
                    ret_state_next = ST_RUN;
                    state_next     = ST_FREEZE;
                end else if (hz && (LOAD_LAT > 1)) begin
                    rem_next   = REM_INIT;
                    state_next = ST_LU_STALL;
                end
            end
            ST_LU_STALL: begin
                if (pipe.dmem_busy) begin
                    ret_state_next = ST_LU_STALL;
                    state_next     = ST_FREEZE;
                end else begin
                    rem_next = rem - 2'd1;
                    if (rem == 2'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_FREEZE: begin
                if (!pipe.dmem_busy) begin
                    state_next = ret_state;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        ctrl = ctrl_run(pipe.branch_taken);
        unique case (state)
            ST_RUN: begin
                if (pipe.dmem_busy) begin
                    ctrl = ctrl_freeze();
                end else if (hz) begin
                    ctrl = ctrl_stall();
                end
            end
            ST_LU_STALL: begin
                ctrl = pipe.dmem_busy ? ctrl_freeze() : ctrl_stall();
            end
            ST_FREEZE: begin
                ctrl = ctrl_freeze();
            end
            default: begin
                ctrl = ctrl_freeze();
            end
        endcase

        pipe.pc_write     = ctrl.pc_write;
        pipe.if_id_write  = ctrl.if_id_write;
        pipe.if_id_flush  = ctrl.if_id_flush;
        pipe.id_ex_write  = ctrl.id_ex_write;
        pipe.id_ex_bubble = ctrl.id_ex_bubble;
        pipe.ex_mem_write = ctrl.ex_mem_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ctrl.if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: three instances (LOAD_LAT 1/2/3)
// share one stimulus stream and are compared every cycle against a
// bubble-debt model, with literal counter expectations for directed cases.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if p1();
    hazard_stall_ctrl_if p2();
    hazard_stall_ctrl_if p3();

    logic [15:0] sc1, sc2, sc3, fc1, fc2, fc3;

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .pipe(p1), .stall_cycles(sc1), .flush_count(fc1));
    hazard_stall_ctrl #(.LOAD_LAT(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .pipe(p2), .stall_cycles(sc2), .flush_count(fc2));
    hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .pipe(p3), .stall_cycles(sc3), .flush_count(fc3));

    // bench-side copies of the inputs
    logic [4:0] in_rs = '0, in_rt = '0, in_ert = '0;
    logic in_uses = 1'b0, in_mr = 1'b0, in_br = 1'b0, in_busy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // literal-expectation requests from the stimulus process
    int     pin_req  = 0;
    int     pin_seen = 0;
    int     pin_kind = 0;
    longint pin_exp[3];

    // model: per instance, bubbles still owed, freeze flag, counters
    int     owed[3];
    bit     frz[3];
    longint msc[3];
    longint mfc[3];

    task automatic chk(input string nm, input int inst, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s lat%0d at %0t: got %0h expected %0h", nm, inst + 1, $time, got, exp);
        end
    endtask

    function automatic bit hz_of();
        return in_mr && (in_ert != 5'd0) &&
               ((in_ert == in_rs) || (in_uses && (in_ert == in_rt)));
    endfunction

    always @(negedge clk) begin
        logic [5:0] got[3];
        longint gsc[3], gfc[3];
        logic [5:0] exp;
        got[0] = {p1.pc_write, p1.if_id_write, p1.if_id_flush, p1.id_ex_write, p1.id_ex_bubble, p1.ex_mem_write};
        got[1] = {p2.pc_write, p2.if_id_write, p2.if_id_flush, p2.id_ex_write, p2.id_ex_bubble, p2.ex_mem_write};
        got[2] = {p3.pc_write, p3.if_id_write, p3.if_id_flush, p3.id_ex_write, p3.id_ex_bubble, p3.ex_mem_write};
        gsc[0] = sc1; gsc[1] = sc2; gsc[2] = sc3;
        gfc[0] = fc1; gfc[1] = fc2; gfc[2] = fc3;

        if (pin_req != pin_seen) begin
            pin_seen = pin_req;
            for (int i = 0; i < 3; i++) begin
                if (pin_kind == 0) chk("pin_stall_cycles", i, gsc[i], pin_exp[i]);
                else if (pin_kind == 1) chk("pin_flush_count", i, gfc[i], pin_exp[i]);
            end
            if (pin_kind == 2) begin
                chk("pin_after_reset_enables", 1,
                    {got[1][5], got[1][4], got[1][2], got[1][0]}, 4'b1111);
                chk("pin_after_reset_stall_cycles", 1, gsc[1], 0);
                chk("pin_after_reset_flush_count", 1, gfc[1], 0);
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                owed[i] = 0; frz[i] = 0; msc[i] = 0; mfc[i] = 0;
            end
            if (frz[i]) begin
                exp = 6'b000000;
                if (!rst) frz[i] = in_busy;
            end else if (in_busy) begin
                exp = 6'b000000;
                if (!rst) frz[i] = 1;
            end else if (owed[i] > 0) begin
                exp = 6'b000111;
                if (!rst) owed[i]--;
            end else if (hz_of()) begin
                exp = 6'b000111;
                if (!rst) owed[i] = i;  // LOAD_LAT-1 more after this one
            end else begin
                exp = {2'b11, in_br, 3'b101};
            end
            chk("ctrl_outputs", i, got[i], exp);
            chk("stall_cycles", i, gsc[i], msc[i]);
            chk("flush_count", i, gfc[i], mfc[i]);
            if (!rst) begin
                if (!exp[5] && msc[i] < 65535) msc[i]++;
                if (exp[3] && mfc[i] < 65535) mfc[i]++;
            end
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mr, input logic [4:0] ert, input logic br, input logic busy);
        in_rs = rs; in_rt = rt; in_uses = uses; in_mr = mr; in_ert = ert; in_br = br; in_busy = busy;
        p1.id_rs = rs; p1.id_rt = rt; p1.id_uses_rt = uses; p1.ex_mem_read = mr; p1.ex_rt = ert; p1.branch_taken = br; p1.dmem_busy = busy;
        p2.id_rs = rs; p2.id_rt = rt; p2.id_uses_rt = uses; p2.ex_mem_read = mr; p2.ex_rt = ert; p2.branch_taken = br; p2.dmem_busy = busy;
        p3.id_rs = rs; p3.id_rt = rt; p3.id_uses_rt = uses; p3.ex_mem_read = mr; p3.ex_rt = ert; p3.branch_taken = br; p3.dmem_busy = busy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input int kind, input longint e0, input longint e1, input longint e2);
        pin_kind = kind;
        pin_exp[0] = e0; pin_exp[1] = e1; pin_exp[2] = e2;
        pin_req++;
        step(1);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        idle();
        step(2);
        rst = 1'b0;
        step(1);

        // reset in the middle of a load-use stall (LOAD_LAT=2 instance)
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(1);
        idle();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pin(2, 0, 0, 0);

        // single-cycle load-use via rs
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(1);
        idle();
        step(4);
        pin(0, 1, 2, 3);

        // load-use via rt, then same registers without rt use
        do_reset();
        drive(5'd1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        step(1);
        idle();
        step(4);
        pin(0, 1, 2, 3);
        drive(5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        step(1);
        idle();
        step(4);
        pin(0, 1, 2, 3);

        // $zero load never stalls; lone taken branch flushes once
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step(1);
        idle();
        step(2);
        pin(0, 0, 0, 0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1);
        idle();
        step(2);
        pin(1, 1, 1, 1);

        // freeze arriving one cycle after the hazard, busy for 3 cycles
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(3);
        idle();
        step(6);
        pin(0, 5, 6, 7);

        // hazard and taken branch together: stall wins, no flush
        do_reset();
        drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        step(1);
        idle();
        step(4);
        pin(1, 0, 0, 0);
        pin(0, 1, 2, 3);

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom % 2),
                  1'($urandom % 2), 5'($urandom_range(0, 3)),
                  1'(($urandom % 100) < 25), 1'(($urandom % 100) < 15));
            rst = (($urandom % 100) == 0);
            step(1);
        end
        rst = 1'b0;
        idle();
        step(4);

        // stall counter saturation
        do_reset();
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        step(65536 + 5);
        idle();
        step(3);
        pin(0, 65535, 65535, 65535);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
